// File: rtl/dmem_responder_if.sv
// Request/response bus between the load/store unit and the data memory responder.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency 64-bit data memory responder with byte strobes and error signalling.
// One request outstanding at a time; the access commits LATENCY cycles after acceptance.
module dmem_responder #(
  parameter int unsigned DEPTH   = 128,
  parameter int unsigned LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int unsigned IDXW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [63:0] ADDR_LIMIT = 64'(DEPTH) * 64'd8;
  localparam logic [3:0]  CNT_INIT   = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        cnt;
  logic              lat_write;
  logic [63:0]       lat_addr;
  logic [63:0]       lat_wdata;
  logic [7:0]        lat_wstrb;
  logic [63:0]       rdata_q;
  logic              err_q;
  logic              accept;
  logic              commit;
  logic              done;
  logic              addr_err;
  logic [IDXW-1:0]   idx;

  logic [63:0] mem [DEPTH];

  assign accept = bus.req_valid && (state == IDLE);
  assign commit = (state == WAIT) && (cnt == '0);
  assign done   = (state == RESP) && bus.resp_ready;

  // Decode the latched address: word index and misaligned/out-of-range error.
  always_comb begin
    idx      = lat_addr[IDXW+2:3];
    addr_err = (lat_addr[2:0] != 3'b000) || (lat_addr >= ADDR_LIMIT);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = WAIT;
      WAIT:    if (commit) state_nxt = RESP;
      RESP:    if (done)   state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  // Bus outputs driven from state and the registered response.
  always_comb begin
    bus.req_ready  = (state == IDLE);
    bus.resp_valid = (state == RESP);
    bus.resp_rdata = rdata_q;
    bus.resp_err   = err_q;
  end

  // Request capture, latency counter and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wstrb <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        lat_write <= bus.req_write;
        lat_addr  <= bus.req_addr;
        lat_wdata <= bus.req_wdata;
        lat_wstrb <= bus.req_wstrb;
        cnt       <= CNT_INIT;
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        rdata_q <= (addr_err || lat_write) ? '0 : mem[idx];
        err_q   <= addr_err;
      end else if (done) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

  // Storage array: not reset so it can be preloaded; writes only on a clean store commit.
  always_ff @(posedge clk) begin
    if (commit && lat_write && !addr_err) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (lat_wstrb[i]) mem[idx][8*i +: 8] <= lat_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the processor's load/store path.
- Answers 64-bit doubleword read (ld) and write (sd) requests over a valid/ready request channel and a valid/ready response channel.
- Models a memory with a fixed, configurable access latency, byte write strobes and error signalling.
- Replaces the processor's zero-latency internal data memory once the core gains a stall-capable memory interface.

Parameters:
- DEPTH, 128, number of 64-bit words; byte address space is 0 .. DEPTH*8-1.
- LATENCY, 2, cycles from request acceptance to response valid; legal range 1..15.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store (sd), 0 = load (ld).
- req_addr  input  64  byte address.
- req_wdata  input  64  store data.
- req_wstrb  input  8  byte enables for a store; bit i enables byte i (little-endian); ignored for loads.
- resp_valid  output  1  response present.
- resp_ready  input  1  requester accepts the response.
- resp_rdata  output  64  load data; 0 for stores and for errors.
- resp_err  output  1  request was misaligned or out of range.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; resp_valid = 0, resp_rdata = 0, resp_err = 0, latency counter = 0.
  - Memory array is not cleared.
- Word index = req_addr >> 3. Memory is preloadable by hierarchical write to the array `mem`.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1; it is 0 in every other state.
  - A request is accepted at a rising edge where req_valid & req_ready. At that edge the responder latches write, addr, wdata and wstrb, loads the counter with LATENCY-1, and moves to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - On the edge where the counter reaches 0, the access commits and the state moves to RESP with resp_valid = 1.
  - resp_valid therefore rises exactly LATENCY cycles after the acceptance edge.
- Commit rules:
  - Error: error if addr[2:0] != 0 or addr >= DEPTH*8. The result is resp_err = 1, resp_rdata = 0, and no memory update.
  - Load: resp_rdata = mem[index].
  - Store: each byte i with wstrb[i] = 1 is replaced by wdata byte i; bytes with wstrb[i] = 0 are unchanged. resp_rdata = 0.
  - A store with wstrb = 0 is legal: no change and no error.
- RESP:
  - resp_valid, resp_rdata and resp_err are held stable until resp_valid & resp_ready at a rising edge.
  - On that edge resp_valid goes to 0 and the state returns to IDLE.
  - A new request can be accepted on the next edge at the earliest.
- Ordering:
  - Only one request is outstanding at a time.
  - req_* inputs are don't-care outside acceptance edges.
  - Changes to req_* during WAIT or RESP have no effect.
- Reset mid-operation: any uncommitted store is dropped (memory unchanged) and any pending response is discarded.
- Read-after-write: a load accepted after a store's response completes returns the stored value.

Test Plan:
- Read latency: preload mem[32] = 64'h1234567890ABCDEF; load at addr 0x100 accepted at edge T, resp_ready = 1 → resp_valid rises at edge T+2 with resp_rdata = 64'h1234567890ABCDEF and resp_err = 0; req_ready is 0 from T to T+3.
- Store then load: store wdata = 64'hB, wstrb = 8'hFF at addr 0x200 → response has resp_rdata = 0 and resp_err = 0; mem[64] = 64'hB. A following load at 0x200 returns 64'hB.
- Byte strobes: preload mem[1] = 64'h1111111111111111; store wdata = 64'hAAAAAAAABBBBBBBB, wstrb = 8'h0F at addr 0x8 → mem[1] = 64'h11111111BBBBBBBB.
- Errors:
  - Load at addr 0x104 → resp_err = 1, resp_rdata = 0.
  - Store at addr 0x400 (DEPTH = 128) → resp_err = 1 and no memory word changes.
- Backpressure: hold resp_ready = 0 for 3 cycles after resp_valid → resp_valid, resp_rdata and resp_err are stable; req_ready stays 0; a req_valid pulse during this time is not accepted. The handshake occurs on the 4th cycle.
- Reset mid-WAIT: accept a store of 64'hFF to 0x200 with mem[64] = 0, then assert reset one cycle later → resp_valid = 0 immediately, mem[64] stays 0, and the state is IDLE after reset is released.
